// File: rtl/i2c_pkg.sv
// Shared types for the I2C target: FSM state encoding, bus event codes and
// the bit-counter width.
package i2c_pkg;

   localparam int BIT_CNT_W = 3;
   localparam logic [BIT_CNT_W-1:0] BIT_LAST = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_WR_BYTE   = 3'd3,
      ST_WR_ACK    = 3'd4,
      ST_RD_BYTE   = 3'd5,
      ST_RD_ACK    = 3'd6,
      ST_WAIT_STOP = 3'd7
   } i2c_state_e;

   typedef enum logic [1:0] {
      EV_NONE  = 2'd0,
      EV_START = 2'd1,
      EV_STOP  = 2'd2
   } bus_event_e;

   // START outranks STOP so a malformed glitch always restarts addressing.
   function automatic bus_event_e bus_event(input logic start_det, input logic stop_det);
      bus_event_e ev;
      if (start_det) begin
         ev = EV_START;
      end else if (stop_det) begin
         ev = EV_STOP;
      end else begin
         ev = EV_NONE;
      end
      return ev;
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA and decodes SCL edges plus START/STOP conditions
// from the synchronized levels against their previous-cycle values.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync_r;
   logic [SYNC_STAGES-1:0] sda_sync_r;
   logic                   scl_prev_r;
   logic                   sda_prev_r;

   // Synchronizer chains and previous-cycle copies; idle bus level is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_sync_r <= {SYNC_STAGES{1'b1}};
         sda_sync_r <= {SYNC_STAGES{1'b1}};
         scl_prev_r <= 1'b1;
         sda_prev_r <= 1'b1;
      end else begin
         scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
         sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
         scl_prev_r <= scl_sync_r[SYNC_STAGES-1];
         sda_prev_r <= sda_sync_r[SYNC_STAGES-1];
      end
   end

   assign scl       = scl_sync_r[SYNC_STAGES-1];
   assign sda       = sda_sync_r[SYNC_STAGES-1];
   assign scl_rise  =  scl & ~scl_prev_r;
   assign scl_fall  = ~scl &  scl_prev_r;
   assign start_det =  scl &  scl_prev_r &  sda_prev_r & ~sda;
   assign stop_det  =  scl &  scl_prev_r & ~sda_prev_r &  sda;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, write-byte delivery and read-byte serialization.
// Optional clock stretching on read bytes is enabled by I2C_SLAVE_STRETCH_EN.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDR        = 7'h21,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       scl_oe,
   output logic       busy,
   output logic       rw,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
`ifdef I2C_SLAVE_STRETCH_EN
   input  logic       tx_valid,
`endif
   output logic       tx_req,
   output logic       nack
);

`ifdef I2C_SLAVE_STRETCH_EN
   localparam logic STRETCH_EN = 1'b1;
`else
   localparam logic STRETCH_EN = 1'b0;
`endif

   logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_det_s, stop_det_s;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
      .clk       (clk),
      .reset     (reset),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .scl       (scl_s),
      .sda       (sda_s),
      .scl_rise  (scl_rise_s),
      .scl_fall  (scl_fall_s),
      .start_det (start_det_s),
      .stop_det  (stop_det_s)
   );

   i2c_state_e           state_r, state_s;
   logic [BIT_CNT_W-1:0] cnt_r, cnt_s;
   logic [7:0]           shift_r, shift_s;
   logic                 flag_r, flag_s;
   logic                 sda_oe_r, sda_oe_s;
   logic                 stretch_r, stretch_s;
   logic                 busy_r, busy_s;
   logic                 rw_r, rw_s;
   logic [7:0]           rx_data_r, rx_data_s;
   logic                 rx_valid_r, rx_valid_s;
   logic                 tx_req_r, tx_req_s;
   logic                 nack_r, nack_s;
   logic                 tx_load_s;
   logic                 scl_unused_s;

`ifdef I2C_SLAVE_STRETCH_EN
   assign tx_load_s = stretch_r & tx_valid;
`else
   assign tx_load_s = 1'b0;
`endif
   assign scl_unused_s = scl_s;

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 3'd0;
         shift_r    <= 8'h00;
         flag_r     <= 1'b0;
         sda_oe_r   <= 1'b0;
         stretch_r  <= 1'b0;
         busy_r     <= 1'b0;
         rw_r       <= 1'b0;
         rx_data_r  <= 8'h00;
         rx_valid_r <= 1'b0;
         tx_req_r   <= 1'b0;
         nack_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         shift_r    <= shift_s;
         flag_r     <= flag_s;
         sda_oe_r   <= sda_oe_s;
         stretch_r  <= stretch_s;
         busy_r     <= busy_s;
         rw_r       <= rw_s;
         rx_data_r  <= rx_data_s;
         rx_valid_r <= rx_valid_s;
         tx_req_r   <= tx_req_s;
         nack_r     <= nack_s;
      end
   end

   // Next-state and output decode; flag_r marks "byte complete" or "ACK seen".
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      shift_s    = shift_r;
      flag_s     = flag_r;
      sda_oe_s   = sda_oe_r;
      stretch_s  = stretch_r;
      busy_s     = busy_r;
      rw_s       = rw_r;
      rx_data_s  = rx_data_r;
      rx_valid_s = 1'b0;
      tx_req_s   = 1'b0;
      nack_s     = 1'b0;
      case (bus_event(start_det_s, stop_det_s))
         EV_START: begin
            state_s   = ST_ADDR;
            cnt_s     = 3'd0;
            flag_s    = 1'b0;
            shift_s   = 8'h00;
            sda_oe_s  = 1'b0;
            stretch_s = 1'b0;
            busy_s    = 1'b0;
         end
         EV_STOP: begin
            state_s   = ST_IDLE;
            cnt_s     = 3'd0;
            flag_s    = 1'b0;
            sda_oe_s  = 1'b0;
            stretch_s = 1'b0;
            busy_s    = 1'b0;
         end
         default: begin
            case (state_r)
               ST_IDLE: begin
                  sda_oe_s = 1'b0;
               end
               ST_ADDR: begin
                  if (scl_rise_s) begin
                     shift_s = {shift_r[6:0], sda_s};
                     cnt_s   = cnt_r + 3'd1;
                     flag_s  = (cnt_r == BIT_LAST) ? 1'b1 : flag_r;
                  end else if (scl_fall_s && flag_r) begin
                     flag_s = 1'b0;
                     cnt_s  = 3'd0;
                     if (shift_r[7:1] == ADDR) begin
                        rw_s     = shift_r[0];
                        busy_s   = 1'b1;
                        sda_oe_s = 1'b1;
                        state_s  = ST_ADDR_ACK;
                     end else begin
                        state_s  = ST_WAIT_STOP;
                     end
                  end else begin
                     state_s = ST_ADDR;
                  end
               end
               ST_ADDR_ACK, ST_RD_ACK: begin
                  if (tx_load_s) begin
                     shift_s   = tx_data;
                     sda_oe_s  = ~tx_data[7];
                     cnt_s     = 3'd0;
                     stretch_s = 1'b0;
                     state_s   = ST_RD_BYTE;
                  end else if (scl_rise_s) begin
                     if (state_r == ST_RD_ACK && sda_s) begin
                        nack_s  = 1'b1;
                        state_s = ST_WAIT_STOP;
                     end else begin
                        tx_req_s = rw_r;
                        flag_s   = 1'b1;
                     end
                  end else if (scl_fall_s && flag_r) begin
                     flag_s = 1'b0;
                     if (!rw_r) begin
                        sda_oe_s = 1'b0;
                        cnt_s    = 3'd0;
                        state_s  = ST_WR_BYTE;
                     end else if (STRETCH_EN) begin
                        stretch_s = 1'b1;
                     end else begin
                        shift_s  = tx_data;
                        sda_oe_s = ~tx_data[7];
                        cnt_s    = 3'd0;
                        state_s  = ST_RD_BYTE;
                     end
                  end else begin
                     state_s = state_r;
                  end
               end
               ST_WR_BYTE: begin
                  if (scl_rise_s) begin
                     shift_s = {shift_r[6:0], sda_s};
                     cnt_s   = cnt_r + 3'd1;
                     if (cnt_r == BIT_LAST) begin
                        flag_s     = 1'b1;
                        rx_data_s  = {shift_r[6:0], sda_s};
                        rx_valid_s = 1'b1;
                     end else begin
                        flag_s     = flag_r;
                     end
                  end else if (scl_fall_s && flag_r) begin
                     flag_s   = 1'b0;
                     sda_oe_s = 1'b1;
                     state_s  = ST_WR_ACK;
                  end else begin
                     state_s = ST_WR_BYTE;
                  end
               end
               ST_WR_ACK: begin
                  if (scl_fall_s) begin
                     sda_oe_s = 1'b0;
                     cnt_s    = 3'd0;
                     state_s  = ST_WR_BYTE;
                  end else begin
                     state_s  = ST_WR_ACK;
                  end
               end
               ST_RD_BYTE: begin
                  if (scl_fall_s) begin
                     if (cnt_r == BIT_LAST) begin
                        sda_oe_s = 1'b0;
                        cnt_s    = 3'd0;
                        flag_s   = 1'b0;
                        state_s  = ST_RD_ACK;
                     end else begin
                        sda_oe_s = ~shift_r[6];
                        shift_s  = {shift_r[6:0], 1'b0};
                        cnt_s    = cnt_r + 3'd1;
                     end
                  end else begin
                     state_s = ST_RD_BYTE;
                  end
               end
               ST_WAIT_STOP: begin
                  sda_oe_s = 1'b0;
               end
               default: begin
                  state_s  = ST_IDLE;
                  sda_oe_s = 1'b0;
               end
            endcase
         end
      endcase
   end

   assign sda_oe   = sda_oe_r;
   assign scl_oe   = stretch_r;
   assign busy     = busy_r;
   assign rw       = rw_r;
   assign rx_data  = rx_data_r;
   assign rx_valid = rx_valid_r;
   assign tx_req   = tx_req_r;
   assign nack     = nack_r;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: bit-banged I2C master, host responder and
// byte-level reference expectations held in queues/arrays.
module tb_i2c_slave;

   localparam int         Q    = 4;
   localparam logic [6:0] ADDR = 7'h21;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       m_scl_pull = 1'b0;
   logic       m_sda_pull = 1'b0;
   logic       scl_line, sda_line;
   logic       sda_oe, scl_oe, busy, rw, rx_valid, tx_req, nack;
   logic [7:0] rx_data;
   logic [7:0] tx_data = 8'h00;
`ifdef I2C_SLAVE_STRETCH_EN
   logic       tx_valid = 1'b0;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] host_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] data_a[8];
   int tx_req_cnt = 0, nack_cnt = 0, sda_oe_cnt = 0, scl_oe_cnt = 0;

   assign scl_line = ~(m_scl_pull | scl_oe);
   assign sda_line = ~(m_sda_pull | sda_oe);

   always #5 clk = ~clk;

   i2c_slave dut (
      .clk      (clk),
      .reset    (reset),
      .scl_in   (scl_line),
      .sda_in   (sda_line),
      .sda_oe   (sda_oe),
      .scl_oe   (scl_oe),
      .busy     (busy),
      .rw       (rw),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
`ifdef I2C_SLAVE_STRETCH_EN
      .tx_valid (tx_valid),
`endif
      .tx_req   (tx_req),
      .nack     (nack)
   );

   always @(negedge clk) begin
      if (rx_valid) rx_q.push_back(rx_data);
      if (tx_req)   tx_req_cnt++;
      if (nack)     nack_cnt++;
      if (sda_oe)   sda_oe_cnt++;
      if (scl_oe)   scl_oe_cnt++;
   end

`ifdef I2C_SLAVE_STRETCH_EN
   always @(negedge clk) begin
      if (tx_req) begin
         repeat (50) @(negedge clk);
         tx_data  = (host_q.size() > 0) ? host_q.pop_front() : 8'hFF;
         tx_valid = 1'b1;
         @(negedge clk);
         tx_valid = 1'b0;
      end
   end
`else
   always @(negedge clk) begin
      if (tx_req) tx_data = (host_q.size() > 0) ? host_q.pop_front() : 8'hFF;
   end
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wq(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic scl_release();
      int t;
      t = 0;
      m_scl_pull = 1'b0;
      while (scl_line !== 1'b1 && t < 4000) begin
         @(negedge clk);
         t++;
      end
      if (scl_line !== 1'b1) begin
         n_cmp++; n_fail++;
         $display("FAIL scl_release: scl got %b want 1 within 4000 clks", scl_line);
      end
   endtask

   task automatic bus_start();
      m_sda_pull = 1'b0; wq(Q);
      scl_release();     wq(Q);
      m_sda_pull = 1'b1; wq(Q);
      m_scl_pull = 1'b1; wq(Q);
   endtask

   task automatic bus_stop();
      m_sda_pull = 1'b1; wq(Q);
      scl_release();     wq(Q);
      m_sda_pull = 1'b0; wq(Q);
   endtask

   task automatic write_bit(input logic b);
      m_sda_pull = ~b;   wq(Q);
      scl_release();     wq(2*Q);
      m_scl_pull = 1'b1; wq(Q);
   endtask

   task automatic read_bit(output logic b);
      m_sda_pull = 1'b0; wq(Q);
      scl_release();     wq(Q);
      b = sda_line;      wq(Q);
      m_scl_pull = 1'b1; wq(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(input logic last, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(last);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      wq(3);
      n_cmp++;
      if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++;
      if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      n_cmp++;
      if ({scl_oe, rw, rx_valid, tx_req, nack} !== 5'b0) begin
         n_fail++; $display("FAIL reset_misc: got %b want 00000", {scl_oe, rw, rx_valid, tx_req, nack});
      end
      reset = 1'b1;
      wq(10);
   endtask

   task automatic test_write(input int n);
      logic ack;
      int   base;
      base = rx_q.size();
      bus_start();
      write_byte({ADDR, 1'b0}, ack);
      n_cmp++;
      if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack: got %b want 0", ack); end
      for (int i = 0; i < n; i++) begin
         write_byte(data_a[i], ack);
         n_cmp++;
         if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_data_ack[%0d]: got %b want 0", i, ack); end
      end
      n_cmp++;
      if (busy !== 1'b1 || rw !== 1'b0) begin
         n_fail++; $display("FAIL wr_busy_rw: got busy=%b rw=%b want busy=1 rw=0", busy, rw);
      end
      bus_stop();
      wq(8);
      n_cmp++;
      if (rx_q.size() - base != n) begin
         n_fail++; $display("FAIL wr_rx_count: got %0d want %0d", rx_q.size() - base, n);
      end else begin
         for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (rx_q[base+i] !== data_a[i]) begin
               n_fail++; $display("FAIL wr_rx_data[%0d]: got %h want %h", i, rx_q[base+i], data_a[i]);
            end
         end
      end
      n_cmp++;
      if (busy !== 1'b0 || rw !== 1'b0) begin
         n_fail++; $display("FAIL wr_after_stop: got busy=%b rw=%b want 0 0", busy, rw);
      end
   endtask

   task automatic test_mismatch();
      logic ack;
      int   b_rx, b_tx, b_oe;
      b_rx = rx_q.size(); b_tx = tx_req_cnt; b_oe = sda_oe_cnt;
      bus_start();
      write_byte({7'h22, 1'b0}, ack);
      n_cmp++;
      if (ack !== 1'b1) begin n_fail++; $display("FAIL mm_addr_nack: got %b want 1", ack); end
      write_byte(8'($urandom), ack);
      n_cmp++;
      if (ack !== 1'b1) begin n_fail++; $display("FAIL mm_data_nack: got %b want 1", ack); end
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mm_busy: got %b want 0", busy); end
      bus_stop();
      wq(8);
      n_cmp++;
      if (sda_oe_cnt != b_oe || rx_q.size() != b_rx || tx_req_cnt != b_tx) begin
         n_fail++;
         $display("FAIL mm_no_activity: got oe=%0d rx=%0d txreq=%0d want 0 0 0",
                  sda_oe_cnt - b_oe, rx_q.size() - b_rx, tx_req_cnt - b_tx);
      end
   endtask

   task automatic test_read(input int n);
      logic       ack;
      logic [7:0] d;
      int         b_tx, b_nk;
      for (int i = 0; i < n; i++) host_q.push_back(data_a[i]);
      b_tx = tx_req_cnt; b_nk = nack_cnt;
      bus_start();
      write_byte({ADDR, 1'b1}, ack);
      n_cmp++;
      if (ack !== 1'b0 || rw !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL rd_addr: got ack=%b rw=%b busy=%b want 0 1 1", ack, rw, busy);
      end
      for (int i = 0; i < n; i++) begin
         read_byte(i == n - 1, d);
         n_cmp++;
         if (d !== data_a[i]) begin n_fail++; $display("FAIL rd_data[%0d]: got %h want %h", i, d, data_a[i]); end
      end
      n_cmp++;
      if (tx_req_cnt - b_tx != n) begin
         n_fail++; $display("FAIL rd_tx_req_count: got %0d want %0d", tx_req_cnt - b_tx, n);
      end
      n_cmp++;
      if (nack_cnt - b_nk != 1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL rd_nack: got nack=%0d busy=%b want 1 1", nack_cnt - b_nk, busy);
      end
      bus_stop();
      wq(8);
      n_cmp++;
      if (busy !== 1'b0 || sda_oe !== 1'b0) begin
         n_fail++; $display("FAIL rd_after_stop: got busy=%b sda_oe=%b want 0 0", busy, sda_oe);
      end
   endtask

   task automatic test_repeated_start();
      logic       ack;
      logic [7:0] d, r;
      int         b_rx, b_tx;
      r = 8'($urandom);
      b_rx = rx_q.size(); b_tx = tx_req_cnt;
      bus_start();
      write_byte({ADDR, 1'b0}, ack);
      write_byte(8'h12, ack);
      n_cmp++;
      if (ack !== 1'b0) begin n_fail++; $display("FAIL sr_wr_ack: got %b want 0", ack); end
      host_q.push_back(r);
      bus_start();
      write_byte({ADDR, 1'b1}, ack);
      n_cmp++;
      if (ack !== 1'b0 || rw !== 1'b1 || tx_req_cnt - b_tx != 1) begin
         n_fail++; $display("FAIL sr_rd_addr: got ack=%b rw=%b txreq=%0d want 0 1 1", ack, rw, tx_req_cnt - b_tx);
      end
      n_cmp++;
      if (rx_q.size() - b_rx != 1 || rx_q[rx_q.size()-1] !== 8'h12) begin
         n_fail++; $display("FAIL sr_rx: got count=%0d last=%h want 1 12", rx_q.size() - b_rx, rx_q[rx_q.size()-1]);
      end
      read_byte(1'b1, d);
      n_cmp++;
      if (d !== r) begin n_fail++; $display("FAIL sr_rd_data: got %h want %h", d, r); end
      bus_stop();
      wq(8);
   endtask

   task automatic test_reset_mid();
      logic       ack, b;
      logic [7:0] d;
      d = 8'($urandom) & 8'hF7;
      host_q.push_back(d);
      bus_start();
      write_byte({ADDR, 1'b1}, ack);
      for (int i = 7; i >= 4; i--) begin
         read_bit(b);
         n_cmp++;
         if (b !== d[i]) begin n_fail++; $display("FAIL rm_bit[%0d]: got %b want %b", i, b, d[i]); end
      end
      wq(1);
      n_cmp++;
      if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rm_bit3_drive: got %b want 1", sda_oe); end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (sda_oe !== 1'b0 || busy !== 1'b0 || rw !== 1'b0) begin
         n_fail++; $display("FAIL rm_reset_release: got sda_oe=%b busy=%b rw=%b want 0 0 0", sda_oe, busy, rw);
      end
      m_sda_pull = 1'b0;
      m_scl_pull = 1'b0;
      wq(4);
      reset = 1'b1;
      host_q.delete();
      wq(10);
      data_a[0] = 8'($urandom);
      test_write(1);
   endtask

`ifdef I2C_SLAVE_STRETCH_EN
   task automatic test_stretch();
      logic       ack;
      logic [7:0] d;
      int         b_oe;
      host_q.push_back(8'h5A);
      b_oe = scl_oe_cnt;
      bus_start();
      write_byte({ADDR, 1'b1}, ack);
      read_byte(1'b1, d);
      bus_stop();
      wq(8);
      n_cmp++;
      if (d !== 8'h5A) begin n_fail++; $display("FAIL st_data: got %h want 5a", d); end
      n_cmp++;
      if (scl_oe_cnt - b_oe < 30 || scl_oe_cnt - b_oe > 60) begin
         n_fail++; $display("FAIL st_hold: got %0d clks want 30..60", scl_oe_cnt - b_oe);
      end
   endtask
`endif

   initial begin
      test_reset();
      data_a[0] = 8'hF0; data_a[1] = 8'h0F;
      test_write(2);
      for (int i = 0; i < 3; i++) data_a[i] = 8'($urandom);
      test_write(3);
      test_mismatch();
      data_a[0] = 8'hA5; data_a[1] = 8'h3C; data_a[2] = 8'h00; data_a[3] = 8'hFF;
      test_read(4);
      for (int i = 0; i < 3; i++) data_a[i] = 8'($urandom);
      test_read(3);
      test_repeated_start();
      test_reset_mid();
`ifdef I2C_SLAVE_STRETCH_EN
      test_stretch();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
